// File: rtl/ndn_pkg.sv
// Shared types and constants for the PIT front end: FSM states, packet
// kinds and the table_entry layout handed to the PIT.
package ndn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HASH   = 2'd1,
      SEARCH = 2'd2,
      RESULT = 2'd3
   } state_e;

   localparam logic PKT_INTEREST = 1'b0;
   localparam logic PKT_DATA     = 1'b1;

   localparam int ADDR_W  = 10;
   localparam int HIT_BIT = 10;
   localparam int ENTRY_W = ADDR_W + 1;

   function automatic logic [ENTRY_W-1:0] make_entry(input logic hit,
                                                     input logic [ADDR_W-1:0] addr);
      return {hit, addr};
   endfunction

endpackage

// File: rtl/pit_lookup_if.sv
// Packet ingress handshake plus the lookup results presented to the PIT.
interface pit_lookup_if;

   logic                        pkt_valid;
   logic [7:0]                  pkt_byte;
   logic                        pkt_last;
   logic                        pkt_type;
   logic                        pkt_ready;
   logic [ndn_pkg::ENTRY_W-1:0] table_entry;
   logic                        in_bit;
   logic                        out_bit;
   logic                        data_packet;
   logic                        table_full;
   logic                        busy;

   modport master (
      output pkt_valid, pkt_byte, pkt_last, pkt_type,
      input  pkt_ready, table_entry, in_bit, out_bit, data_packet, table_full, busy
   );

   modport slave (
      input  pkt_valid, pkt_byte, pkt_last, pkt_type,
      output pkt_ready, table_entry, in_bit, out_bit, data_packet, table_full, busy
   );

endinterface

// File: rtl/pit_lookup_name_hash.sv
// Rotate-and-xor name hash accumulator; clear wins over a byte update.
module name_hash #(
   parameter int TAG_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [7:0]       byte_i,
   output logic [TAG_W-1:0] hash_o
);

   logic [TAG_W-1:0] hash_q;
   logic [TAG_W-1:0] hash_d;

   always_comb begin
      hash_d = hash_q;
      if (clear_i) begin
         hash_d = '0;
      end else if (en_i) begin
         hash_d = {hash_q[TAG_W-2:0], hash_q[TAG_W-1]} ^ TAG_W'(byte_i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hash_q <= '0;
      end else begin
         hash_q <= hash_d;
      end
   end

   assign hash_o = hash_q;

endmodule

// File: rtl/pit_lookup.sv
// Hashes an incoming name, scans the tag table one slot per cycle, and
// reports hit/allocation results to the PIT with in_bit/out_bit pulses.
module pit_lookup
   import ndn_pkg::*;
#(
   parameter int ENTRIES   = 8,
   parameter int SLOT_BITS = 3,
   parameter int TAG_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   pit_lookup_if.slave bus
);

   state_e                 state_q;
   logic [TAG_W-1:0]       tag_q [ENTRIES];
   logic [ENTRIES-1:0]     valid_q;
   logic [ENTRIES-1:0]     has_data_q;
   logic [SLOT_BITS-1:0]   idx_q;
   logic [SLOT_BITS-1:0]   free_idx_q;
   logic                   free_found_q;
   logic                   type_q;
   logic [ENTRY_W-1:0]     entry_q;
   logic                   in_bit_q;
   logic                   out_bit_q;
   logic                   data_packet_q;
   logic                   table_full_q;

   logic [TAG_W-1:0]       hash;
   logic                   accept;
   logic                   cur_hit;
   logic                   last_idx;
   logic                   free_any;
   logic [SLOT_BITS-1:0]   free_slot;

   assign accept    = bus.pkt_valid && (state_q == IDLE || state_q == HASH);
   assign cur_hit   = valid_q[idx_q] && (tag_q[idx_q] == hash);
   assign last_idx  = (idx_q == SLOT_BITS'(ENTRIES - 1));
   // The slot under inspection counts as free on the final cycle too.
   assign free_any  = free_found_q || !valid_q[idx_q];
   assign free_slot = free_found_q ? free_idx_q : idx_q;

   name_hash #(.TAG_W(TAG_W)) u_hash (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q == RESULT),
      .en_i    (accept),
      .byte_i  (bus.pkt_byte),
      .hash_o  (hash)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         has_data_q    <= '0;
         idx_q         <= '0;
         free_idx_q    <= '0;
         free_found_q  <= 1'b0;
         type_q        <= PKT_INTEREST;
         entry_q       <= '0;
         in_bit_q      <= 1'b0;
         out_bit_q     <= 1'b0;
         data_packet_q <= 1'b0;
         table_full_q  <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         in_bit_q      <= 1'b0;
         out_bit_q     <= 1'b0;
         data_packet_q <= 1'b0;
         table_full_q  <= &valid_q;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  type_q  <= bus.pkt_type;
                  state_q <= bus.pkt_last ? SEARCH : HASH;
               end
            end
            HASH: begin
               if (accept && bus.pkt_last) begin
                  state_q <= SEARCH;
               end
            end
            SEARCH: begin
               if (cur_hit || last_idx) begin
                  state_q <= RESULT;
                  if (cur_hit) begin
                     entry_q <= make_entry(1'b1, {idx_q, {(ADDR_W-SLOT_BITS){1'b0}}});
                     if (type_q == PKT_INTEREST) begin
                        in_bit_q      <= 1'b1;
                        data_packet_q <= has_data_q[idx_q];
                     end else begin
                        out_bit_q         <= 1'b1;
                        has_data_q[idx_q] <= 1'b1;
                     end
                  end else if (type_q == PKT_INTEREST && free_any) begin
                     tag_q[free_slot]      <= hash;
                     valid_q[free_slot]    <= 1'b1;
                     has_data_q[free_slot] <= 1'b0;
                     entry_q  <= make_entry(1'b1, {free_slot, {(ADDR_W-SLOT_BITS){1'b0}}});
                     in_bit_q <= 1'b1;
                  end else begin
                     entry_q   <= '0;
                     in_bit_q  <= (type_q == PKT_INTEREST);
                     out_bit_q <= (type_q == PKT_DATA);
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
                  if (!free_found_q && !valid_q[idx_q]) begin
                     free_found_q <= 1'b1;
                     free_idx_q   <= idx_q;
                  end
               end
            end
            RESULT: begin
               state_q      <= IDLE;
               idx_q        <= '0;
               free_found_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pkt_ready   = (state_q == IDLE) || (state_q == HASH);
   assign bus.busy        = (state_q != IDLE);
   assign bus.table_entry = entry_q;
   assign bus.in_bit      = in_bit_q;
   assign bus.out_bit     = out_bit_q;
   assign bus.data_packet = data_packet_q;
   assign bus.table_full  = table_full_q;

endmodule

// File: tb/tb_pit_lookup.sv
// Directed bench for pit_lookup: allocation, hits, data marking, full table,
// unsolicited data and asynchronous reset in the middle of a packet.
module tb_pit_lookup;

   logic clk = 1'b0;
   logic reset;

   pit_lookup_if bus ();

   pit_lookup #(.ENTRIES(8), .SLOT_BITS(3), .TAG_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [10:0] r_entry;
   logic        r_in;
   logic        r_out;
   logic        r_dp;
   int          ready_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one packet (n = 1 or 2 bytes, first byte in name[15:8] when n = 2),
   // then wait for the result pulse. With junk set, pkt_valid stays asserted
   // with a bogus byte while the lookup is busy.
   task automatic send_pkt(input logic typ, input logic [15:0] name, input int n,
                           input logic junk);
      logic got;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.pkt_valid = 1'b1;
         bus.pkt_byte  = (n == 2 && i == 0) ? name[15:8] : name[7:0];
         bus.pkt_last  = (i == n - 1);
         bus.pkt_type  = typ;
      end
      @(negedge clk);
      if (junk) begin
         bus.pkt_byte = 8'h99;
         bus.pkt_last = 1'b1;
      end else begin
         bus.pkt_valid = 1'b0;
      end
      got       = 1'b0;
      ready_bad = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (bus.in_bit || bus.out_bit) begin
            got = 1'b1;
         end else begin
            if (bus.pkt_ready) ready_bad++;
            @(negedge clk);
         end
      end
      bus.pkt_valid = 1'b0;
      if (bus.pkt_ready) ready_bad++;
      r_entry = bus.table_entry;
      r_in    = bus.in_bit;
      r_out   = bus.out_bit;
      r_dp    = bus.data_packet;
      chk("result_seen", 32'(got), 32'd1);
      $display("pkt type=%0d name=%h -> entry=%h in=%0d out=%0d dp=%0d",
               typ, name, r_entry, r_in, r_out, r_dp);
      @(negedge clk);
      chk("pulse_one_cycle", 32'(bus.in_bit | bus.out_bit), 32'd0);
   endtask

   initial begin
      reset         = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.pkt_byte  = 8'h00;
      bus.pkt_last  = 1'b0;
      bus.pkt_type  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_entry", 32'(bus.table_entry), 32'h000);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_pulses", 32'({bus.in_bit, bus.out_bit, bus.data_packet}), 32'd0);
      chk("rst_ready", 32'(bus.pkt_ready), 32'd1);
      chk("rst_full", 32'(bus.table_full), 32'd0);
      reset = 1'b1;

      // Interest "ab" on empty table allocates slot 0
      send_pkt(1'b0, 16'h6162, 2, 1'b0);
      chk("ab_alloc_entry", 32'(r_entry), 32'h400);
      chk("ab_alloc_in", 32'({r_in, r_out}), 32'b10);
      chk("ab_alloc_dp", 32'(r_dp), 32'd0);
      chk("ab_alloc_ready", 32'(ready_bad), 32'd0);

      // Repeat interest hits slot 0
      send_pkt(1'b0, 16'h6162, 2, 1'b0);
      chk("ab_hit_entry", 32'(r_entry), 32'h400);
      chk("ab_hit_dp", 32'(r_dp), 32'd0);
      chk("ab_hit_full", 32'(bus.table_full), 32'd0);

      // Data "ab" marks slot 0
      send_pkt(1'b1, 16'h6162, 2, 1'b0);
      chk("ab_data_entry", 32'(r_entry), 32'h400);
      chk("ab_data_pulse", 32'({r_in, r_out}), 32'b01);

      send_pkt(1'b0, 16'h6162, 2, 1'b0);
      chk("ab_after_data_entry", 32'(r_entry), 32'h400);
      chk("ab_after_data_dp", 32'(r_dp), 32'd1);

      // Single-byte names 1..7 fill slots 1..7
      for (int k = 1; k < 8; k++) begin
         send_pkt(1'b0, 16'(k), 1, 1'b0);
         chk("fill_entry", 32'(r_entry), 32'h400 | (32'(k) << 7));
         chk("fill_full", 32'(bus.table_full), (k == 7) ? 32'd1 : 32'd0);
      end

      // Ninth distinct interest: table full
      send_pkt(1'b0, 16'h0008, 1, 1'b0);
      chk("full_entry", 32'(r_entry), 32'h000);
      chk("full_pulse", 32'({r_in, r_out, r_dp}), 32'b100);

      // Unsolicited data "zz"
      send_pkt(1'b1, 16'h7a7a, 2, 1'b0);
      chk("zz_entry", 32'(r_entry), 32'h000);
      chk("zz_pulse", 32'({r_in, r_out}), 32'b01);

      send_pkt(1'b0, 16'h0005, 1, 1'b0);
      chk("slot5_hit_entry", 32'(r_entry), 32'h680);
      chk("slot5_hit_dp", 32'(r_dp), 32'd0);
      send_pkt(1'b0, 16'h6162, 2, 1'b0);
      chk("ab_still_data", 32'({r_entry, r_dp}), {20'h0, 12'h801});

      // Reset in the middle of a packet
      @(negedge clk);
      bus.pkt_valid = 1'b1;
      bus.pkt_byte  = 8'h11;
      bus.pkt_last  = 1'b0;
      bus.pkt_type  = 1'b0;
      @(negedge clk);
      bus.pkt_byte  = 8'h22;
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      chk("midpkt_busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_entry", 32'(bus.table_entry), 32'h000);
      chk("midrst_full", 32'(bus.table_full), 32'd0);
      chk("midrst_pulses", 32'({bus.in_bit, bus.out_bit, bus.data_packet}), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Single-byte packet with stray valid bytes during the lookup
      send_pkt(1'b0, 16'h0042, 1, 1'b1);
      chk("post_rst_entry", 32'(r_entry), 32'h400);
      chk("post_rst_ready", 32'(ready_bad), 32'd0);
      send_pkt(1'b0, 16'h0043, 1, 1'b0);
      chk("post_rst_slot1", 32'(r_entry), 32'h480);
      send_pkt(1'b0, 16'h0042, 1, 1'b0);
      chk("post_rst_rehit", 32'(r_entry), 32'h400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pit_lookup.md
Name: pit_lookup

Overview:
Upstream stage of the PIT. Takes a packet's name bytes from the ingress parser and hashes them into a 16-bit tag. It then searches a small tag table for a matching pending-interest slot and hands the PIT a table_entry {hit, address}. It also raises the PIT's in_bit / out_bit / data_packet controls, and owns slot allocation and release for the PIT memory.

Parameters:
ENTRIES, 8, number of PIT slots; power of two, 2..64.
SLOT_BITS, 3, log2(ENTRIES).
TAG_W, 16, hash/tag width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low; clears all state.
pkt_valid  in  1  pkt_byte is valid this cycle.
pkt_byte  in  8  name byte.
pkt_last  in  1  final name byte, qualified by pkt_valid.
pkt_type  in  1  0 = interest, 1 = data; sampled on the first accepted byte.
pkt_ready  out  1  high in IDLE and HASH only.
table_entry  out  11  [10] = hit or allocated, [9:0] = slot base address {slot, (10-SLOT_BITS) zeros}.
in_bit  out  1  one-cycle pulse: interest result valid.
out_bit  out  1  one-cycle pulse: data result valid.
data_packet  out  1  qualified by in_bit; the hit slot already holds data.
table_full  out  1  level; all slots valid.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (low): state = IDLE, every valid and has_data bit = 0, hash = 0, table_entry = 0, and every pulse output = 0. Takes effect immediately, including mid-packet. The partial packet is dropped.
- Hash: on each accepted byte, hash <= {hash[TAG_W-2:0], hash[TAG_W-1]} ^ {8'h00, pkt_byte}. Hash is cleared on entry to IDLE.
- IDLE: pkt_valid captures pkt_type, applies the first byte, then moves to HASH. If pkt_last is also high, go straight to SEARCH.
- HASH: accept bytes while pkt_valid. Idle cycles (pkt_valid = 0) are allowed. Accepting a byte with pkt_last high moves to SEARCH.
- SEARCH: one slot per cycle, index 0 to ENTRIES-1.
  - hit = valid[i] && tag[i] == hash. The first hit ends the search immediately.
  - Also record the lowest-index free slot seen.
  - Worst-case latency is ENTRIES cycles from the last byte to RESULT.
- RESULT (one cycle). table_entry is registered here and held until the next RESULT.
  - Interest, hit: entry = {1, slot}; data_packet = has_data[slot]; in_bit = 1.
  - Interest, miss, free slot: write tag, valid = 1, has_data = 0; entry = {1, free}; data_packet = 0; in_bit = 1.
  - Interest, miss, table full: entry = {0, 0}; in_bit = 1 (the PIT drops it).
  - Data, hit: entry = {1, slot}; has_data[slot] = 1; out_bit = 1.
  - Data, miss (unsolicited): entry = {0, 0}; out_bit = 1.
  - In every case, return to IDLE next cycle.
- in_bit and out_bit are never high together, and each is high for exactly one cycle per packet.
- pkt_ready = 0 in SEARCH and RESULT. Upstream must hold its bytes; any pkt_valid there is ignored.
- table_full updates the cycle after an allocation.
- Slots are never freed in this revision except by reset.

Decomposition:
- Shared package ndn_pkg:
  - state enum IDLE / HASH / SEARCH / RESULT;
  - PKT_INTEREST = 0, PKT_DATA = 1;
  - table_entry field positions (HIT_BIT = 10, ADDR = 9:0);
  - the PIT address width of 10.
- One sub-module is natural: name_hash. It is the combinational next-hash function plus the registered accumulator with a clear input.

Test Plan:
- Interest "ab" (8'h61, 8'h62) on an empty table → after SEARCH, table_entry = 11'h400 (slot 0), in_bit pulses 1 cycle, data_packet = 0, valid[0] = 1.
- Same interest repeated → hit on slot 0; table_entry = 11'h400; no new allocation; table_full stays 0.
- Data "ab" → out_bit pulses, table_entry = 11'h400, has_data[0] = 1. A following interest "ab" → in_bit with data_packet = 1.
- Fill all 8 slots with distinct names, then a 9th new interest → table_full = 1 and table_entry = 11'h000 with in_bit. Slot 7 address = 11'h780.
- Unsolicited data "zz" → out_bit with table_entry[10] = 0; the table is unchanged.
- Reset asserted mid-HASH after 2 bytes → busy = 0 and all outputs 0 immediately. A new single-byte packet with pkt_last on byte 1 then completes normally; pkt_ready stays 0 throughout SEARCH.
